dcache: RTL and testbench
=========================

// Module: dcache
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the core's word-wide load/store port and memory_bus.
//  Acts as the master of memory_interface: issues whole-line refills and victim writebacks to the memory slave.
//  Hits complete combinationally in the request cycle; misses stall the core until the line is resident.
// PARAMETERS
//  SIZE        4*1024*8  cache data capacity in bits
//  LINE_SIZE   32*8      line width in bits; must equal the memory slave's LINE_SIZE
//  ADDR_SIZE   32        byte address width
//  WORD_SIZE   32        core data width in bits; NUM_LINES=SIZE/LINE_SIZE, OFFSET_BITS=$clog2(LINE_SIZE/8)
// PORTS
//  clk_i           in   1           clock; all state on posedge
//  reset_i         in   1           asynchronous, active-high reset
//  cpu_valid_i     in   1           core request present; held with all cpu_* inputs until cpu_ready_o
//  cpu_write_i     in   1           1=store, 0=load
//  cpu_addr_i      in   ADDR_SIZE   byte address; bits[1:0] ignored (word aligned)
//  cpu_wr_data_i   in   WORD_SIZE   store data
//  cpu_wr_strb_i   in   WORD_SIZE/8 store byte enables
//  cpu_rd_data_o   out  WORD_SIZE   load data, valid while cpu_ready_o
//  cpu_ready_o     out  1           request completes this cycle
//  memory_bus      master modport of memory_interface: addr, valid, write, wr_data (out); rd_data, ready (in)
// BEHAVIOUR
//  - Addr split: tag | index[INDEX_BITS] | offset[OFFSET_BITS]; word select = offset[OFFSET_BITS-1:2].
//  - Per line: valid bit, dirty bit, tag, data. Data array is not reset.
//  - Reset: state=IDLE; all valid and dirty bits=0.
//    cpu_ready_o=0, memory_bus.valid=0, memory_bus.write=0, memory_bus.addr=0, memory_bus.wr_data=0.
//  - Reset asserted mid-transaction abandons it immediately; no partial line is marked valid.
//  - FSM states: IDLE, WRITEBACK, REFILL.
//  - IDLE: hit = cpu_valid_i & valid[index] & tag match.
//    - Hit: cpu_ready_o=1 in the same cycle, with cpu_rd_data_o = selected word.
//    - Store hit: merge strobed bytes at the posedge and set dirty.
//    - Miss with victim valid & dirty: go to WRITEBACK.
//    - Miss otherwise: go to REFILL.
//    - No request: stay in IDLE.
//  - WRITEBACK: memory_bus.valid=1, write=1, addr={victim tag,index,0}, wr_data=victim line.
//    Held stable until valid&ready, then go to REFILL.
//  - REFILL: memory_bus.valid=1, write=0, addr={req tag,index,0}.
//    On valid&ready: capture memory_bus.rd_data into the line, set tag, valid=1, dirty=0, go to IDLE.
//    The request then hits in IDLE; a store merges on that hit.
//  - Handshake: a transfer occurs only in a cycle with valid&ready. While waiting, addr, write and wr_data must not change.
//    valid never drops before acceptance. rd_data is sampled only in the accept cycle.
//  - memory_bus.valid=0 in IDLE; cpu_ready_o=0 outside IDLE.
//  - Latency with an idle memory:
//    - Hit: 0 cycles.
//    - Clean miss: ready in cycle 2 (0 = miss cycle).
//    - Dirty miss with DELAY_CYCLES=5: writeback accepted in cycle 1, refill accepted in cycle 7, ready in cycle 8.
//  - The request is never reordered: cpu_* inputs are held by the core, so the FSM latches nothing from the core except via the held inputs.
//  - At most one outstanding memory transaction; memory ready=0 simply extends WRITEBACK/REFILL.
// TESTING
//  - Reset, then load 0x100 (memory line preloaded with pattern) -> one refill at addr 0x100, load returns word, cpu_ready_o in cycle 2.
//  - Load 0x104 after that -> hit, no memory_bus.valid, cpu_ready_o same cycle.
//  - Store 0xDEADBEEF strb 4'b0011 to 0x100, then load -> 0x????BEEF merged, no memory traffic.
//  - Load conflicting addr 0x100+SIZE/8 -> writeback of dirty line to 0x100 (wr_data holds merged bytes), then refill; ready in cycle 8.
//  - Memory holds ready=0 for 10 cycles during REFILL -> addr/valid stable throughout, completes on first ready.
//  - Assert reset_i mid-WRITEBACK -> memory_bus.valid=0 immediately; next access to 0x100 misses.

Source files
------------

// File: rtl/memory_interface_if.sv
// ============================================================================
// Module      : memory_interface
// Description : Line-wide valid/ready bus between the data cache and memory.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface memory_interface #(
  parameter int ADDR_SIZE = 32,
  parameter int LINE_SIZE = 32*8
);
  logic [ADDR_SIZE-1:0] addr;
  logic                 valid;
  logic                 write;
  logic [LINE_SIZE-1:0] wr_data;
  logic [LINE_SIZE-1:0] rd_data;
  logic                 ready;

  modport master (output addr, valid, write, wr_data, input rd_data, ready);
  modport slave  (input addr, valid, write, wr_data, output rd_data, ready);
endinterface

`default_nettype wire

// File: rtl/dcache.sv
// ============================================================================
// Module      : dcache
// Description : Direct-mapped write-back / write-allocate data cache.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache #(
  parameter int SIZE      = 4*1024*8,
  parameter int LINE_SIZE = 32*8,
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
) (
  input  wire logic                   clk_i,
  input  wire logic                   reset_i,
  input  wire logic                   cpu_valid_i,
  input  wire logic                   cpu_write_i,
  input  wire logic [ADDR_SIZE-1:0]   cpu_addr_i,
  input  wire logic [WORD_SIZE-1:0]   cpu_wr_data_i,
  input  wire logic [WORD_SIZE/8-1:0] cpu_wr_strb_i,
  output logic      [WORD_SIZE-1:0]   cpu_rd_data_o,
  output logic                        cpu_ready_o,
  memory_interface.master             memory_bus
);

  localparam int NUM_LINES   = SIZE / LINE_SIZE;
  localparam int OFFSET_BITS = $clog2(LINE_SIZE / 8);
  localparam int INDEX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_BITS    = ADDR_SIZE - INDEX_BITS - OFFSET_BITS;
  localparam int BYTE_BITS   = $clog2(WORD_SIZE / 8);
  localparam int WSEL_BITS   = OFFSET_BITS - BYTE_BITS;
  localparam int STRB_W      = WORD_SIZE / 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_REFILL    = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;

  logic [LINE_SIZE-1:0] data_mem [NUM_LINES];
  logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic [WSEL_BITS-1:0]  req_word;
  logic [LINE_SIZE-1:0]  line_rd;
  logic [LINE_SIZE-1:0]  line_merged;
  logic [TAG_BITS-1:0]   victim_tag;
  logic [WORD_SIZE-1:0]  rd_word;
  logic                  hit;

  logic                  data_we;
  logic [LINE_SIZE-1:0]  data_wdata;
  logic                  tag_we;

  logic                  mem_valid;
  logic                  mem_write;
  logic [ADDR_SIZE-1:0]  mem_addr;
  logic [LINE_SIZE-1:0]  mem_wr_data;

  // Byte lane bits of the address are not used for a word-aligned port.
  logic unused_byte_bits;
  assign unused_byte_bits = ^cpu_addr_i[BYTE_BITS-1:0];

  assign req_tag    = cpu_addr_i[ADDR_SIZE-1 -: TAG_BITS];
  assign req_index  = cpu_addr_i[OFFSET_BITS +: INDEX_BITS];
  assign req_word   = cpu_addr_i[BYTE_BITS +: WSEL_BITS];
  assign line_rd    = data_mem[req_index];
  assign victim_tag = tag_mem[req_index];
  assign rd_word    = line_rd[int'(req_word)*WORD_SIZE +: WORD_SIZE];

  assign hit = cpu_valid_i && (state_q == ST_IDLE) && valid_q[req_index]
               && (victim_tag == req_tag);

  always_comb begin
    line_merged = line_rd;
    for (int b = 0; b < STRB_W; b++) begin
      if (cpu_wr_strb_i[b]) begin
        line_merged[int'(req_word)*WORD_SIZE + b*8 +: 8] = cpu_wr_data_i[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    data_we     = 1'b0;
    data_wdata  = line_merged;
    tag_we      = 1'b0;
    cpu_ready_o = 1'b0;
    mem_valid   = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_valid_i) begin
          if (hit) begin
            cpu_ready_o = 1'b1;
            if (cpu_write_i) begin
              data_we            = 1'b1;
              dirty_d[req_index] = 1'b1;
            end
          end else if (valid_q[req_index] && dirty_q[req_index]) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_REFILL;
          end
        end
      end
      ST_WRITEBACK: begin
        mem_valid   = 1'b1;
        mem_write   = 1'b1;
        mem_addr    = {victim_tag, req_index, {OFFSET_BITS{1'b0}}};
        mem_wr_data = line_rd;
        if (memory_bus.ready) begin
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        mem_valid = 1'b1;
        mem_addr  = {req_tag, req_index, {OFFSET_BITS{1'b0}}};
        if (memory_bus.ready) begin
          data_we            = 1'b1;
          data_wdata         = memory_bus.rd_data;
          tag_we             = 1'b1;
          valid_d[req_index] = 1'b1;
          dirty_d[req_index] = 1'b0;
          state_d            = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cpu_rd_data_o      = hit ? rd_word : '0;
  assign memory_bus.valid   = mem_valid;
  assign memory_bus.write   = mem_write;
  assign memory_bus.addr    = mem_addr;
  assign memory_bus.wr_data = mem_wr_data;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Storage arrays carry no reset; the valid bits alone qualify their content.
  always_ff @(posedge clk_i) begin
    if (data_we) begin
      data_mem[req_index] <= data_wdata;
    end
    if (tag_we) begin
      tag_mem[req_index] <= req_tag;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache.sv
// ============================================================================
// Module      : tb_dcache
// Description : Scoreboard testbench for dcache with a behavioural memory slave.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_valid;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_strb;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;

  int   compared   = 0;
  int   mismatched = 0;
  int   rd_delay   = 0;
  int   rd_cnt     = 0;
  logic stall      = 1'b0;

  typedef struct {logic is_load; logic [31:0] data; int lat;} cpu_exp_t;
  typedef struct {logic write; logic [31:0] addr; logic [63:0] wlo;} mem_exp_t;
  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  logic [255:0] mem [logic [31:0]];

  memory_interface #(.ADDR_SIZE(32), .LINE_SIZE(256)) mem_if ();

  dcache #(.SIZE(4*1024*8), .LINE_SIZE(256), .ADDR_SIZE(32), .WORD_SIZE(32)) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .cpu_valid_i   (cpu_valid),
    .cpu_write_i   (cpu_write),
    .cpu_addr_i    (cpu_addr),
    .cpu_wr_data_i (cpu_wdata),
    .cpu_wr_strb_i (cpu_strb),
    .cpu_rd_data_o (cpu_rdata),
    .cpu_ready_o   (cpu_ready),
    .memory_bus    (mem_if)
  );

  always #5 clk = ~clk;

  // Preloaded pattern: word w of the line at A is {C0DE, A[15:0] + 4w}.
  function automatic logic [255:0] pat_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {16'hC0DE, a[15:0] + 16'(w*4)};
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pat_line(a);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Memory slave: writes accepted at once, reads after rd_delay waiting cycles.
  assign mem_if.ready = mem_if.valid && !stall && (mem_if.write || rd_cnt >= rd_delay);

  always_ff @(posedge clk) begin
    if (mem_if.valid && !mem_if.ready) rd_cnt <= rd_cnt + 1;
    else rd_cnt <= 0;
  end

  initial begin
    mem_if.rd_data = '0;
    forever begin
      @(negedge clk);
      if (mem_if.valid && mem_if.ready && mem_if.write) mem[mem_if.addr] = mem_if.wr_data;
      mem_if.rd_data = mem_line(mem_if.addr);
    end
  end

  // Monitor: memory handshakes, request hold stability and core responses.
  initial begin
    int           lat;
    logic         pend;
    logic [31:0]  p_addr;
    logic         p_write;
    logic [255:0] p_wdata;
    mem_exp_t     me;
    cpu_exp_t     ce;
    lat  = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lat  = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("mem_hold_valid", mem_if.valid, 1'b1);
          chk("mem_hold_addr", mem_if.addr, p_addr);
          chk("mem_hold_write", mem_if.write, p_write);
          chk("mem_hold_wdata", mem_if.wr_data, p_wdata);
        end
        pend    = mem_if.valid && !mem_if.ready;
        p_addr  = mem_if.addr;
        p_write = mem_if.write;
        p_wdata = mem_if.wr_data;
        if (mem_if.valid && mem_if.ready) begin
          if (mem_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL mem_unexpected: got txn addr %0h write %0b want none", mem_if.addr, mem_if.write);
          end else begin
            me = mem_q.pop_front();
            chk("mem_write", mem_if.write, me.write);
            chk("mem_addr", mem_if.addr, me.addr);
            if (me.write) chk("wb_data", mem_if.wr_data[63:0], me.wlo);
          end
        end
        if (cpu_valid) begin
          if (cpu_ready) begin
            chk("idle_mem_valid", mem_if.valid, 1'b0);
            if (cpu_q.size() == 0) begin
              compared++;
              mismatched++;
              $display("FAIL cpu_unexpected: got ready for addr %0h want none", cpu_addr);
            end else begin
              ce = cpu_q.pop_front();
              chk("cpu_latency", lat, ce.lat);
              if (ce.is_load) chk("cpu_rdata", cpu_rdata, ce.data);
            end
            lat = 0;
          end else begin
            lat++;
          end
        end else begin
          lat = 0;
        end
      end
    end
  end

  task automatic cpu_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp_d, input int exp_lat);
    cpu_exp_t e;
    e.is_load = !wr;
    e.data    = exp_d;
    e.lat     = exp_lat;
    cpu_q.push_back(e);
    cpu_valid = 1'b1;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_strb  = s;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cpu_ready) break;
    end
    if (!cpu_ready) begin
      compared++;
      mismatched++;
      $display("FAIL cpu_timeout: addr %0h got no ready want ready within 60 cycles", a);
      cpu_q.delete();
    end
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic exp_mem(input logic wr, input logic [31:0] a, input logic [63:0] wlo);
    mem_exp_t e;
    e.write = wr;
    e.addr  = a;
    e.wlo   = wlo;
    mem_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_ready"}, cpu_ready, 1'b0);
    chk({tag, "_mem_valid"}, mem_if.valid, 1'b0);
    chk({tag, "_mem_write"}, mem_if.write, 1'b0);
    chk({tag, "_mem_addr"}, mem_if.addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_if.wr_data, 256'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cpu_valid = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_strb  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clean miss, then hits, then a store merge on a hit.
    exp_mem(1'b0, 32'h100, 64'h0);
    cpu_req(1'b0, 32'h100, 32'h0, 4'h0, 32'hC0DE0100, 2);
    cpu_req(1'b0, 32'h104, 32'h0, 4'h0, 32'hC0DE0104, 0);
    cpu_req(1'b1, 32'h100, 32'hDEADBEEF, 4'b0011, 32'h0, 0);
    cpu_req(1'b0, 32'h100, 32'h0, 4'h0, 32'hC0DEBEEF, 0);

    // Conflicting line forces writeback of the merged line before refill.
    rd_delay = 5;
    exp_mem(1'b1, 32'h100, {32'hC0DE0104, 32'hC0DEBEEF});
    exp_mem(1'b0, 32'h1100, 64'h0);
    cpu_req(1'b0, 32'h1100, 32'h0, 4'h0, 32'hC0DE1100, 8);
    rd_delay = 0;

    // Refill held off for ten cycles by the memory.
    stall = 1'b1;
    exp_mem(1'b0, 32'h200, 64'h0);
    fork
      cpu_req(1'b0, 32'h200, 32'h0, 4'h0, 32'hC0DE0200, 12);
      begin
        repeat (11) @(posedge clk);
        #1;
        stall = 1'b0;
      end
    join

    // Dirty the line at index 8, then reset in the middle of its writeback.
    cpu_req(1'b1, 32'h1104, 32'h12345678, 4'hF, 32'h0, 0);
    stall     = 1'b1;
    cpu_valid = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    chk("wb_pending_valid", mem_if.valid, 1'b1);
    chk("wb_pending_write", mem_if.write, 1'b1);
    chk("wb_pending_addr", mem_if.addr, 32'h1100);
    rst       = 1'b1;
    cpu_valid = 1'b0;
    #1;
    chk("rst_async_mem_valid", mem_if.valid, 1'b0);
    @(posedge clk);
    #1;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Everything was invalidated: 0x100 misses and refills without a writeback.
    exp_mem(1'b0, 32'h100, 64'h0);
    cpu_req(1'b0, 32'h100, 32'h0, 4'h0, 32'hC0DEBEEF, 2);

    repeat (3) @(negedge clk);
    chk("mem_q_drained", mem_q.size(), 0);
    chk("cpu_q_drained", cpu_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
